// File: rtl/sequenciador_estados_pkg.sv
// Shared sequencer encodings: state codes, tipo constants and the latched
// instruction-field bundle used by the sequencer and the control generator.
package sequenciador_estados_pkg;

  typedef enum logic [3:0] {
    BUSCA      = 4'b0000,
    DECODIFICA = 4'b0001,
    EXECUTA    = 4'b0010,
    ESPERA     = 4'b0011,
    ESCRITA    = 4'b1111,
    PARADO     = 4'b1000
  } estado_t;

  localparam logic [2:0] TIPO_LW   = 3'b000;
  localparam logic [2:0] TIPO_ADDI = 3'b001;
  localparam logic [2:0] TIPO_SW   = 3'b010;
  localparam logic [2:0] TIPO_R    = 3'b011;
  localparam logic [2:0] TIPO_BR   = 3'b110;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [2:0] tipo;
  } campos_t;

  function automatic logic tipo_valido(
    input logic [2:0] t
  );
    logic v;
    v = 1'b0;
    case (t)
      TIPO_LW,
      TIPO_ADDI,
      TIPO_SW,
      TIPO_R,
      TIPO_BR: v = 1'b1;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Branch is taken for beq on zero or bne on non-zero only.
  function automatic logic desvio_tomado(
    input campos_t c,
    input logic    z
  );
    logic t;
    t = 1'b0;
    if (c.tipo == TIPO_BR) begin
      if (c.funct3 == F3_BEQ) t = z;
      else if (c.funct3 == F3_BNE) t = ~z;
    end
    return t;
  endfunction

endpackage

// File: rtl/sequenciador_estados_registrador_instrucao.sv
// Instruction-field latch: loads tipo/funct3/funct7 on the fetch strobe.
// Ports: clk, reset (async high), carga, campos_in -> campos (held).
module registrador_instrucao
  import sequenciador_estados_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    carga,
  input  campos_t campos_in,
  output campos_t campos
);

  campos_t campos_q;
  campos_t campos_d;

  always_comb begin
    campos_d = campos_q;
    if (carga) campos_d = campos_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) campos_q <= '0;
    else       campos_q <= campos_d;
  end

  assign campos = campos_q;

endmodule

// File: rtl/sequenciador_estados.sv
// Multi-cycle instruction sequencer with fetch handshake, halt and retire count.
// Ports: clk, reset, instrucao, mem_pronta, zero -> estado, fields, strobes, flags, instrucoes.
module sequenciador_estados
  import sequenciador_estados_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrucao,
  input  logic        mem_pronta,
  input  logic        zero,
  output logic [3:0]  estado,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic        irwrite,
  output logic        pcwrite,
  output logic        pcsrc,
  output logic        parado,
  output logic        invalida,
  output logic [15:0] instrucoes
);

  estado_t     estado_q, estado_d;
  logic        parado_q, parado_d;
  logic        invalida_q, invalida_d;
  logic [15:0] instrucoes_q, instrucoes_d;

  campos_t campos_in;
  campos_t campos;

  assign campos_in = '{
    funct7: instrucao[31:25],
    funct3: instrucao[14:12],
    tipo:   instrucao[6:4]
  };

  registrador_instrucao u_ri (
    .clk       (clk),
    .reset     (reset),
    .carga     (irwrite),
    .campos_in (campos_in),
    .campos    (campos)
  );

  always_comb begin
    estado_d     = estado_q;
    parado_d     = parado_q;
    invalida_d   = invalida_q;
    instrucoes_d = instrucoes_q;
    irwrite      = 1'b0;
    pcwrite      = 1'b0;
    pcsrc        = 1'b0;
    case (estado_q)
      BUSCA: begin
        // Gate on reset so the strobe drops with the async clear.
        if (mem_pronta && !reset) begin
          irwrite = 1'b1;
          if (instrucao == 32'h0000_0000) begin
            estado_d = PARADO;
            parado_d = 1'b1;
          end else begin
            estado_d = DECODIFICA;
          end
        end
      end
      DECODIFICA: begin
        if (tipo_valido(campos.tipo)) begin
          estado_d = EXECUTA;
        end else begin
          estado_d   = ESCRITA;
          invalida_d = 1'b1;
        end
      end
      EXECUTA: estado_d = ESPERA;
      ESPERA:  estado_d = ESCRITA;
      ESCRITA: begin
        pcwrite      = 1'b1;
        pcsrc        = desvio_tomado(campos, zero);
        estado_d     = BUSCA;
        instrucoes_d = instrucoes_q + 16'd1;
      end
      PARADO: begin
        estado_d = PARADO;
        parado_d = 1'b1;
      end
      default: estado_d = BUSCA;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= BUSCA;
      parado_q     <= 1'b0;
      invalida_q   <= 1'b0;
      instrucoes_q <= 16'h0000;
    end else begin
      estado_q     <= estado_d;
      parado_q     <= parado_d;
      invalida_q   <= invalida_d;
      instrucoes_q <= instrucoes_d;
    end
  end

  assign estado     = estado_q;
  assign tipo       = campos.tipo;
  assign funct3     = campos.funct3;
  assign funct7     = campos.funct7;
  assign parado     = parado_q;
  assign invalida   = invalida_q;
  assign instrucoes = instrucoes_q;

endmodule

// File: doc/sequenciador_estados.md
SEQUENCIADOR_ESTADOS -- requirements
Module: sequenciador_estados

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 instrucao  in  32  instruction word from instruction memory; valid when mem_pronta=1.
REQ-004 mem_pronta  in  1  fetch handshake; memory word on instrucao is valid this cycle.
REQ-005 zero  in  1  ALU zero flag; sampled only in ESCRITA.
REQ-006 estado  out  4  current sequencer state; drives the control-signal generator.
REQ-007 tipo  out  3  latched instrucao[6:4].
REQ-008 funct3  out  3  latched instrucao[14:12].
REQ-009 funct7  out  7  latched instrucao[31:25].
REQ-010 irwrite  out  1  instruction-register load strobe.
REQ-011 pcwrite  out  1  PC update strobe.
REQ-012 pcsrc  out  1  0 = PC+4, 1 = branch target.
REQ-013 parado  out  1  halted, sticky.
REQ-014 invalida  out  1  unsupported tipo seen, sticky.
REQ-015 instrucoes  out  16  retired-instruction count.

Function
REQ-016 State encodings SHALL be: BUSCA 0000, DECODIFICA 0001, EXECUTA 0010, ESPERA 0011, ESCRITA 1111, PARADO 1000.
REQ-017 estado SHALL be a registered output equal to the current state.
REQ-018 BUSCA: SHALL hold while mem_pronta=0, with irwrite=0.
REQ-019 BUSCA with mem_pronta=1: irwrite SHALL be 1 combinationally.
REQ-020 Same BUSCA edge with mem_pronta=1: tipo, funct3 and funct7 SHALL load from instrucao.
REQ-021 Same edge, next state: PARADO if instrucao==32'h00000000, else DECODIFICA.
REQ-022 DECODIFICA: tipo in {000,001,010,011,110} SHALL go to EXECUTA.
REQ-023 DECODIFICA: any other tipo SHALL go to ESCRITA and set invalida.
REQ-024 EXECUTA SHALL go to ESPERA; ESPERA SHALL go to ESCRITA (one cycle each, unconditionally).
REQ-025 ESCRITA: pcwrite SHALL be 1 combinationally; next state SHALL be BUSCA.
REQ-026 ESCRITA: pcsrc=1 iff tipo==110 and ((funct3==000 and zero=1) or (funct3==001 and zero=0)); otherwise pcsrc=0.
REQ-027 pcwrite and pcsrc SHALL be 0 in every state except ESCRITA; irwrite SHALL be 0 outside BUSCA.
REQ-028 instrucoes SHALL increment by 1 on each ESCRITA->BUSCA edge, including invalid instructions.
REQ-029 instrucoes SHALL wrap from 16'hFFFF to 16'h0000.
REQ-030 PARADO SHALL be absorbing until reset; parado=1 in it.
REQ-031 PARADO: no strobes SHALL be asserted and instrucoes SHALL not increment.
REQ-032 tipo/funct3/funct7 SHALL hold their values outside the BUSCA load edge.
REQ-033 Latency: a non-halting instruction SHALL occupy 5 cycles after mem_pronta is seen (BUSCA through ESCRITA); an invalid one SHALL occupy 3.

Reset
REQ-034 On reset assertion, outputs SHALL immediately (asynchronously) be: estado=0000, tipo=000, funct3=000, funct7=0000000, parado=0, invalida=0, instrucoes=0; irwrite, pcwrite and pcsrc SHALL be 0.
REQ-035 Reset asserted in any state, including mid-instruction or PARADO, SHALL abandon that state; after release, operation SHALL restart in BUSCA.

Structure
REQ-036 State encodings and tipo constants (LW 000, ADDI 001, SW 010, R 011, BR 110) SHALL live in a shared package used with the control-signal generator.
REQ-037 The instruction-field latch SHALL be one sub-module, registrador_instrucao; the FSM and counter SHALL remain in the top module.

Verification
REQ-038 add 0x002081B3 with mem_pronta=1 -> estado 0000,0001,0010,0011,1111,0000; tipo=011, funct3=000, funct7=0; pcwrite=1 only in 1111; pcsrc=0; instrucoes=1.
REQ-039 mem_pronta=0 for 3 cycles, then 1 -> estado stays 0000 with irwrite=0 for 3 cycles, then irwrite=1 for exactly 1 cycle.
REQ-040 beq 0x00208463 with zero=1 in ESCRITA -> pcsrc=1; same instruction with zero=0 -> pcsrc=0; bne (funct3=001) with zero=0 -> pcsrc=1.
REQ-041 instrucao=0x00000000 -> estado=1000, parado=1; no pcwrite for 20 cycles; instrucoes unchanged.
REQ-042 0x00000073 (tipo 111) -> 0001 then 1111; invalida=1 and stays 1; pcwrite=1 with pcsrc=0; instrucoes increments.
REQ-043 reset pulsed during EXECUTA -> estado=0000 before the next edge with all outputs at reset values; separately, instrucoes preloaded to 16'hFFFF by 65535 retirements -> next retirement gives 16'h0000.
